// File: rtl/user_event_reader.sv
// user_event_reader: FIFO-buffered user_input reader merged with gravity ticks onto a valid/ready stream.
// Define USER_EVENT_READER_SPEEDUP_EN to add level_i, which shortens the gravity period.
package user_event_pkg;
  typedef enum logic [2:0] {
    EV_NONE, EV_LEFT, EV_RIGHT, EV_UP, EV_DOWN, EV_ROTATE, EV_DROP, EV_NEW_GAME
  } user_event_t;
endpackage

module user_event_reader
  import user_event_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int GRAVITY_DIV = 25_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  user_event_t             user_event_i,
  input  logic                    user_event_ready_i,
  output logic                    user_event_rd_req_o,
  input  logic                    gravity_en_i,
`ifdef USER_EVENT_READER_SPEEDUP_EN
  input  logic [3:0]              level_i,
`endif
  output user_event_t             evt_o,
  output logic                    evt_gravity_o,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [$clog2(DEPTH):0]  fifo_count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GRAVITY_DIV + 1);
  typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;
  rd_state_t state_q, state_d;
  user_event_t mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] grav_cnt_q, grav_cnt_d, period;
  logic pend_q, pend_d;
  user_event_t evt_q, evt_d, head;
  logic grav_q, grav_d, valid_q, valid_d;
  logic rd_req, wr, head_avail, load, pop, grav_take, clr, tick, lvl_chg;
`ifdef USER_EVENT_READER_SPEEDUP_EN
  logic [3:0] level_q;
  logic [GW-1:0] shifted;
  always_comb begin
    shifted = GW'(GRAVITY_DIV) >> level_i;
    period  = shifted < GW'(4) ? GW'(4) : shifted;
    lvl_chg = level_i != level_q;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) level_q <= '0;
    else        level_q <= level_i;
`else
  always_comb begin
    period  = GW'(GRAVITY_DIV);
    lvl_chg = 1'b0;
  end
`endif
  always_comb begin
    wr         = state_q == RD_WAIT;
    // gated by rst_i so the pop strobe drops with the async reset, not at the next edge
    rd_req     = rst_i && state_q == RD_IDLE && user_event_ready_i && count_q < CW'(DEPTH);
    state_d    = rd_req ? RD_WAIT : RD_IDLE;
    // an empty FIFO being written hands the incoming event straight to the output stage
    head_avail = wr || count_q != '0;
    head       = count_q != '0 ? mem_q[rd_ptr_q] : user_event_i;
    load       = !valid_q || evt_ready_i;
    pop        = load && head_avail;
    grav_take  = load && !head_avail && pend_q;
    valid_d    = load ? head_avail || pend_q : valid_q;
    evt_d      = !load ? evt_q : head_avail ? head : pend_q ? EV_DOWN : EV_NONE;
    grav_d     = !load ? grav_q : grav_take;
    wr_ptr_d   = wr_ptr_q + PW'(wr);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(wr) - CW'(pop);
    clr        = !gravity_en_i || (wr && user_event_i == EV_NEW_GAME);
    tick       = gravity_en_i && grav_cnt_q >= period - GW'(1);
    grav_cnt_d = (clr || tick || lvl_chg) ? '0 : grav_cnt_q + GW'(1);
    pend_d     = clr ? 1'b0 : pend_q ? !grav_take : tick;
  end
  always_ff @(posedge clk_i)
    if (wr) mem_q[wr_ptr_q] <= user_event_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q    <= RD_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      grav_cnt_q <= '0;
      pend_q     <= 1'b0;
      evt_q      <= EV_NONE;
      grav_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      grav_cnt_q <= grav_cnt_d;
      pend_q     <= pend_d;
      evt_q      <= evt_d;
      grav_q     <= grav_d;
      valid_q    <= valid_d;
    end
  assign user_event_rd_req_o = rd_req;
  assign evt_o               = evt_q;
  assign evt_gravity_o       = grav_q;
  assign evt_valid_o         = valid_q;
  assign fifo_count_o        = count_q;
endmodule

// File: tb/tb_user_event_reader.sv
// tb_user_event_reader: randomized scoreboard bench for user_event_reader against a queue-based reference model.
module tb_user_event_reader;
  import user_event_pkg::*;
  localparam int DEPTH = 4;
  localparam int DIV   = 16;
  logic clk = 0;
  logic rst_i = 1;
  user_event_t user_event_i = EV_NONE;
  logic user_event_ready_i = 0, rd_req, gravity_en_i = 0, evt_ready_i = 0;
  user_event_t evt_o;
  logic evt_gravity_o, evt_valid_o;
  logic [2:0] fifo_count_o;

  user_event_reader #(.DEPTH(DEPTH), .GRAVITY_DIV(DIV)) dut (
    .clk_i(clk), .rst_i(rst_i), .user_event_i(user_event_i),
    .user_event_ready_i(user_event_ready_i), .user_event_rd_req_o(rd_req),
    .gravity_en_i(gravity_en_i),
`ifdef USER_EVENT_READER_SPEEDUP_EN
    .level_i(4'd0),
`endif
    .evt_o(evt_o), .evt_gravity_o(evt_gravity_o), .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i), .fifo_count_o(fifo_count_o));

  always #5 clk = ~clk;

  typedef struct packed { user_event_t e; logic g; } exp_t;
  int vectors = 0, errors = 0, grav_acc = 0;
  user_event_t src[$];
  exp_t exp_q[$];
  bit did_req = 0;

  // reference model: user-side queue, FIFO as a queue, one output slot, gravity counter
  user_event_t m_fifo[$];
  bit m_wait = 0, m_ov = 0, m_og = 0, m_pend = 0, m_req, m_load, m_take, m_tick, m_ng;
  user_event_t m_oe = EV_NONE;
  int m_cnt = 0;

  task automatic chk(string name, int act, int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_wait = 0; m_ov = 0; m_og = 0; m_oe = EV_NONE; m_cnt = 0; m_pend = 0;
      m_fifo.delete();
      exp_q.delete();
    end else begin
      m_req = !m_wait && user_event_ready_i && m_fifo.size() < DEPTH;
      m_ng  = m_wait && user_event_i == EV_NEW_GAME;
      if (m_wait) m_fifo.push_back(user_event_i);
      m_load = !m_ov || evt_ready_i;
      m_take = 0;
      if (m_load) begin
        if (m_fifo.size() > 0) begin
          m_oe = m_fifo.pop_front(); m_og = 0; m_ov = 1;
        end else if (m_pend) begin
          m_oe = EV_DOWN; m_og = 1; m_ov = 1; m_take = 1;
        end else begin
          m_oe = EV_NONE; m_og = 0; m_ov = 0;
        end
        if (m_ov) exp_q.push_back('{m_oe, m_og});
      end
      if (!gravity_en_i || m_ng) begin
        m_cnt = 0; m_pend = 0;
      end else begin
        m_tick = m_cnt == DIV - 1;
        m_pend = m_pend ? !m_take : m_tick;
        m_cnt  = m_tick ? 0 : m_cnt + 1;
      end
      m_wait = m_req;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_i && evt_valid_o && evt_ready_i) begin
      if (exp_q.size() == 0) chk("accept_with_empty_scoreboard", 1, 0);
      else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("evt", evt_o, x.e);
        chk("evt_gravity", evt_gravity_o, x.g);
        if (x.g) grav_acc++;
      end
    end
  end

  task automatic step(int p_evt, int p_rdy, bit gen);
    @(negedge clk);
    if ($urandom_range(99) < p_evt) src.push_back(user_event_t'($urandom_range(1, 7)));
    user_event_i       = did_req ? src.pop_front() : user_event_t'($urandom_range(0, 7));
    user_event_ready_i = src.size() > 0;
    evt_ready_i        = $urandom_range(99) < p_rdy;
    gravity_en_i       = gen;
    #1;
    chk("rd_req", rd_req, !m_wait && user_event_ready_i && m_fifo.size() < DEPTH);
    chk("evt_valid", evt_valid_o, m_ov);
    chk("fifo_count", fifo_count_o, m_fifo.size());
    did_req = rd_req;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_evt_valid", evt_valid_o, 0);
    chk("rst_evt", evt_o, EV_NONE);
    chk("rst_evt_gravity", evt_gravity_o, 0);
    chk("rst_fifo_count", fifo_count_o, 0);
  endtask

  initial begin
    int n, pulses;
    #1 rst_i = 0;
    user_event_ready_i = 1;
    #12;
    chk_reset_outputs();
    @(negedge clk) rst_i = 1;

    src.push_back(EV_LEFT);
    n = 0;
    while (!did_req && n < 10) begin step(0, 100, 0); n++; end
    chk("single_req_seen", did_req, 1);
    n = 0;
    do begin step(0, 100, 0); n++; end while (!evt_valid_o && n < 10);
    chk("single_latency", n, 2);
    chk("single_evt", evt_o, EV_LEFT);
    repeat (4) step(0, 100, 0);

    repeat (8) src.push_back(user_event_t'($urandom_range(1, 6)));
    pulses = 0;
    repeat (24) begin step(0, 0, 0); pulses += int'(did_req); end
    chk("full_pulses", pulses, DEPTH + 1);
    chk("full_count", fifo_count_o, DEPTH);
    repeat (30) step(0, 100, 0);

    grav_acc = 0;
    repeat (40) step(0, 100, 1);
    chk("gravity_accepts_40", grav_acc, 2);
    repeat (64) step(0, 0, 1);
    src.push_back(EV_UP);
    repeat (4) step(0, 0, 1);
    repeat (6) step(0, 100, 1);

    repeat (3000) step(30, 60, $urandom_range(99) < 95);

    repeat (20) step(0, 100, 0);
    repeat (2) src.push_back(EV_RIGHT);
    n = 0;
    while (!(did_req && evt_valid_o) && n < 40) begin step(0, 0, 0); n++; end
    chk("reset_setup_reached", n < 40, 1);
    step(0, 0, 0);
    #2 rst_i = 0;
    #1;
    chk_reset_outputs();
    did_req = 0;
    @(negedge clk) rst_i = 1;
    repeat (300) step(20, 80, 1);
    repeat (40) step(0, 100, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/user_event_reader.md
Name: user_event_reader

Overview:
- Consumer end of the user_input event interface, in the main game-logic clock domain.
- Pops user_event_t entries from user_input via user_event_ready/user_event_rd_req and buffers them in a small FIFO.
- Merges them with periodic gravity "down" events from an internal tick counter.
- Presents one event at a time to the game FSM over a valid/ready handshake.

Parameters:
- DEPTH, 4: user-event FIFO depth, in entries; power of two, ≥2.
- GRAVITY_DIV, 25_000_000: gravity period in clk_i cycles; ≥4.

Ports:
- clk_i  in  1  main logic clock.
- rst_i  in  1  asynchronous reset, active-low.
- user_event_i  in  user_event_t  event data from user_input; valid the cycle after rd_req.
- user_event_ready_i  in  1  user_input has ≥1 event queued.
- user_event_rd_req_o  out  1  one-cycle pop strobe to user_input.
- gravity_en_i  in  1  game running; gravity counter runs only when high.
- evt_o  out  user_event_t  event to game FSM.
- evt_gravity_o  out  1  current evt_o came from the gravity counter.
- evt_valid_o  out  1  evt_o/evt_gravity_o valid.
- evt_ready_i  in  1  game FSM accepts the event.
- fifo_count_o  out  $clog2(DEPTH)+1  user FIFO occupancy, for debug.

Behaviour:
- Reset (rst_i low, async):
  - rd_req_o=0, evt_valid_o=0, evt_o=EV_NONE, evt_gravity_o=0, fifo_count_o=0.
  - Gravity counter=0, gravity_pending=0, FSM=RD_IDLE.
  - FIFO contents are don't-care.
- Read FSM (one outstanding request at a time):
  - RD_IDLE: if user_event_ready_i && (count + 1) ≤ DEPTH, assert rd_req_o for exactly one cycle and go to RD_WAIT.
  - RD_WAIT: on the next cycle, write user_event_i into the FIFO and go to RD_IDLE.
  - Maximum pop rate: one per 2 cycles. rd_req_o is never asserted in RD_WAIT.
  - Space check includes the outstanding entry, so the FIFO never overflows. With the FIFO full, rd_req_o stays 0 and user_input keeps its queue.
- FIFO: circular buffer; ptr width $clog2(DEPTH), wrapping naturally. Simultaneous write and output pop leave the count unchanged.
- Gravity:
  - The counter increments while gravity_en_i=1. At GRAVITY_DIV-1 it wraps to 0 and sets gravity_pending.
  - A tick while gravity_pending is already set is dropped (saturating, one pending max).
  - gravity_en_i=0 clears the counter and gravity_pending.
- Output stage (registered, one entry):
  - Loads when empty, or when evt_valid_o && evt_ready_i in the same cycle, giving zero-bubble back-to-back transfer.
  - Source priority: FIFO head first. Otherwise gravity_pending, which loads EV_DOWN with evt_gravity_o=1 and clears the flag.
  - Latency: FIFO write at cycle N → evt_valid_o at N+1, if the output stage is free.
  - evt_o/evt_gravity_o hold stable while evt_valid_o && !evt_ready_i.
- Flush: when an EV_NEW_GAME event is written into the FIFO, clear gravity_pending and the gravity counter in that same cycle. Queued user events remain.
- Reset mid-operation: an outstanding rd_req is abandoned. The user_input entry already popped is lost; this is accepted.

Optional Feature:
- Macro: USER_EVENT_READER_SPEEDUP_EN.
- Defined:
  - Adds input level_i [3:0].
  - Gravity period = GRAVITY_DIV >> level_i, floored at 4 cycles.
  - A level_i change resets the counter in the next cycle.
- Undefined: no level_i port; fixed period GRAVITY_DIV.

Test Plan:
- Single event: GRAVITY_DIV=16, gravity_en_i=0; user_event_ready_i=1 for one event EV_LEFT, evt_ready_i=1 → rd_req_o pulses 1 cycle; evt_valid_o=1 with evt_o=EV_LEFT, evt_gravity_o=0 exactly 2 cycles after rd_req_o.
- FIFO full: DEPTH=4, evt_ready_i=0, user_event_ready_i held 1 → output stage plus 4 FIFO entries fill (5 rd_req pulses total, spaced 2 cycles apart), then rd_req_o stays 0 and fifo_count_o=4. Raising evt_ready_i drains the events in order, with no loss or duplication.
- Gravity: GRAVITY_DIV=16, gravity_en_i=1, no user events, evt_ready_i=1 → EV_DOWN with evt_gravity_o=1 every 16 cycles. With evt_ready_i=0 for 64 cycles, exactly one gravity event is presented.
- Priority: gravity_pending=1 and FIFO holding EV_UP when the output frees → EV_UP is delivered first, then EV_DOWN (gravity) on the next accept.
- New game: gravity_pending=1, then EV_NEW_GAME is read → pending cleared and counter=0. The next gravity event arrives GRAVITY_DIV cycles later.
- Async reset asserted during RD_WAIT with evt_valid_o=1 → all outputs at reset values immediately, without waiting for a clock edge; normal operation resumes after release.
